// File: rtl/demux_1_to_4_buf_if.sv
// Handshake bundle for demux_1_to_4_buf: one producer-side channel
// (in_*) and four consumer-side channels (out_*_k).
// With DEMUX_DROP_EN defined the bundle also carries drop_count.
interface demux_1_to_4_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out_data_0;
    logic [WIDTH-1:0] out_data_1;
    logic [WIDTH-1:0] out_data_2;
    logic [WIDTH-1:0] out_data_3;
    logic             out_valid_0;
    logic             out_valid_1;
    logic             out_valid_2;
    logic             out_valid_3;
    logic             out_ready_0;
    logic             out_ready_1;
    logic             out_ready_2;
    logic             out_ready_3;
`ifdef DEMUX_DROP_EN
    logic [7:0]       drop_count;
`endif

    // Environment side: producer plus the four consumers.
    modport master (
        output in_data, output in_sel, output in_valid,
        input  in_ready,
        input  out_data_0, input out_data_1, input out_data_2, input out_data_3,
        input  out_valid_0, input out_valid_1, input out_valid_2, input out_valid_3,
        output out_ready_0, output out_ready_1, output out_ready_2, output out_ready_3
`ifdef DEMUX_DROP_EN
        , input drop_count
`endif
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, input in_sel, input in_valid,
        output in_ready,
        output out_data_0, output out_data_1, output out_data_2, output out_data_3,
        output out_valid_0, output out_valid_1, output out_valid_2, output out_valid_3,
        input  out_ready_0, input out_ready_1, input out_ready_2, input out_ready_3
`ifdef DEMUX_DROP_EN
        , output drop_count
`endif
    );
endinterface

// File: rtl/demux_1_to_4_buf.sv
// demux_1_to_4_buf: registered 1-to-4 demultiplexer with valid/ready.
// Each output port owns a one-entry holding register (slot + full flag).
// A port that pops and is pushed in the same cycle takes the new word
// without a bubble.
// Optional feature macro DEMUX_DROP_EN: in_ready is tied high, words
// aimed at a full, non-popping port are discarded and counted in a
// saturating 8-bit drop_count.
module demux_1_to_4_buf #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_1_to_4_buf_if.slave   bus
);

    logic [3:0]       r_full;
    logic [WIDTH-1:0] r_slot [4];

    logic [3:0]       w_out_ready;
    logic [3:0]       w_pop;
    logic [3:0]       w_push;
    logic             w_port_ready;
    logic             w_accept;

    assign w_out_ready  = {bus.out_ready_3, bus.out_ready_2, bus.out_ready_1, bus.out_ready_0};
    assign w_pop        = r_full & w_out_ready;

    // The selected port can take a word if it is empty or draining this cycle.
    assign w_port_ready = ~r_full[bus.in_sel] | w_out_ready[bus.in_sel];

`ifdef DEMUX_DROP_EN
    assign bus.in_ready = 1'b1;
`else
    assign bus.in_ready = w_port_ready;
`endif

    assign w_accept = bus.in_valid & bus.in_ready;

    // One-hot write enable for the destination slot; an accept into a
    // blocked port (drop build only) writes nothing.
    always_comb begin
        w_push = 4'b0000;
        if (w_accept && w_port_ready) begin
            w_push[bus.in_sel] = 1'b1;
        end
    end

    // Full flags: set on push, cleared on a pop that has no matching push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 4'b0000;
        end else begin
            r_full <= (r_full & ~w_pop) | w_push;
        end
    end

    // Holding registers: load the incoming word into the pushed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_push[k]) begin
                    r_slot[k] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_valid_0 = r_full[0];
    assign bus.out_valid_1 = r_full[1];
    assign bus.out_valid_2 = r_full[2];
    assign bus.out_valid_3 = r_full[3];
    assign bus.out_data_0  = r_slot[0];
    assign bus.out_data_1  = r_slot[1];
    assign bus.out_data_2  = r_slot[2];
    assign bus.out_data_3  = r_slot[3];

`ifdef DEMUX_DROP_EN
    logic       w_drop;
    logic [7:0] r_drop_count;

    assign w_drop = w_accept & ~w_port_ready;

    // Saturating count of words discarded at a blocked port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign bus.drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Scoreboard bench for demux_1_to_4_buf. The reference model is a set of
// per-port FIFOs of expected words (at most one committed word each).
// Works for both the default build and the DEMUX_DROP_EN build.
module tb_demux_1_to_4_buf;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1_to_4_buf_if #(.WIDTH(WIDTH)) bus ();
    demux_1_to_4_buf #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected contents per port, oldest first. A word accepted for the
    // coming edge is flagged by pend/pend_sel until the monitor sees it.
    logic [WIDTH-1:0] exp_q [4][$];
    logic pend      = 1'b0;
    int   pend_sel  = 0;
    logic pend_drop = 1'b0;
    int   exp_drop  = 0;
    logic mon_en    = 1'b0;

    function automatic logic get_valid(input int k);
        case (k)
            0: return bus.out_valid_0;
            1: return bus.out_valid_1;
            2: return bus.out_valid_2;
            default: return bus.out_valid_3;
        endcase
    endfunction

    function automatic logic get_ready(input int k);
        case (k)
            0: return bus.out_ready_0;
            1: return bus.out_ready_1;
            2: return bus.out_ready_2;
            default: return bus.out_ready_3;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] get_data(input int k);
        case (k)
            0: return bus.out_data_0;
            1: return bus.out_data_1;
            2: return bus.out_data_2;
            default: return bus.out_data_3;
        endcase
    endfunction

    // Monitor: checks visible port state and retires popped words.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                int committed;
                committed = exp_q[k].size() - ((pend && pend_sel == k) ? 1 : 0);
                n_cmp++;
                if (get_valid(k) !== (committed > 0)) begin
                    n_fail++;
                    $display("FAIL out_valid_%0d: got %b expected %b at %0t", k, get_valid(k), committed > 0, $time);
                end
                if (committed > 0) begin
                    n_cmp++;
                    if (get_data(k) !== exp_q[k][0]) begin
                        n_fail++;
                        $display("FAIL out_data_%0d: got %h expected %h at %0t", k, get_data(k), exp_q[k][0], $time);
                    end
                    if (get_ready(k)) void'(exp_q[k].pop_front());
                end
            end
`ifdef DEMUX_DROP_EN
            n_cmp++;
            if (bus.drop_count !== 8'(exp_drop)) begin
                n_fail++;
                $display("FAIL drop_count: got %0d expected %0d at %0t", bus.drop_count, exp_drop, $time);
            end
            if (pend_drop && exp_drop < 255) exp_drop++;
`endif
            pend      = 1'b0;
            pend_drop = 1'b0;
        end
    end

    // One cycle of stimulus; predicts in_ready and records the expected word.
    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] rdy, output logic acc);
        logic room, exp_rdy;
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.in_sel      = s;
        bus.in_data     = d;
        bus.out_ready_0 = rdy[0];
        bus.out_ready_1 = rdy[1];
        bus.out_ready_2 = rdy[2];
        bus.out_ready_3 = rdy[3];
        #1;
        room = (exp_q[s].size() == 0) || rdy[s];
`ifdef DEMUX_DROP_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = room;
`endif
        n_cmp++;
        if (bus.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready sel=%0d: got %b expected %b at %0t", s, bus.in_ready, exp_rdy, $time);
        end
        acc = v && exp_rdy;
        if (acc) begin
            if (room) begin
                exp_q[s].push_back(d);
                pend     = 1'b1;
                pend_sel = s;
            end else begin
                pend_drop = 1'b1;
            end
        end
    endtask

    task automatic check_all_clear(input string tag);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (get_valid(k) !== 1'b0 || get_data(k) !== '0) begin
                n_fail++;
                $display("FAIL %s port%0d: got valid=%b data=%h expected 0/0", tag, k, get_valid(k), get_data(k));
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic reset_mid();
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.out_ready_0 = 1'b0;
        bus.out_ready_1 = 1'b0;
        bus.out_ready_2 = 1'b0;
        bus.out_ready_3 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_clear("async_reset");
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        exp_drop  = 0;
        pend      = 1'b0;
        pend_drop = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        logic hv;
        logic [1:0] hs;
        logic [WIDTH-1:0] hd;

        bus.in_valid    = 1'b0;
        bus.in_sel      = 2'd0;
        bus.in_data     = '0;
        bus.out_ready_0 = 1'b0;
        bus.out_ready_1 = 1'b0;
        bus.out_ready_2 = 1'b0;
        bus.out_ready_3 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_clear("reset");
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready sel=%0d: got %b expected 1", s, bus.in_ready);
            end
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single word to port 2, nobody consuming.
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);
        // Port 1 full and stalled, then released.
        drive(1'b1, 2'd1, 32'h1111_0001, 4'b0000, acc);
        drive(1'b1, 2'd1, 32'h1111_0002, 4'b0000, acc);
        drive(1'b1, 2'd1, 32'h1111_0002, 4'b0000, acc);
        drive(1'b1, 2'd1, 32'h1111_0002, 4'b0010, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);
        // Back-to-back stream into port 0 with its consumer always ready.
        for (int i = 1; i <= 8; i++) drive(1'b1, 2'd0, WIDTH'(i), 4'b0001, acc);
        drive(1'b0, 2'd0, '0, 4'b1111, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);

        // Reset while ports 0 and 3 hold words.
        drive(1'b1, 2'd0, 32'hA0A0_A0A0, 4'b0000, acc);
        drive(1'b1, 2'd3, 32'hB3B3_B3B3, 4'b0000, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);
        reset_mid();

`ifdef DEMUX_DROP_EN
        // Flood a stalled port: every extra word is discarded and counted.
        drive(1'b1, 2'd0, 32'h0BAD_F00D, 4'b0000, acc);
        for (int i = 0; i < 300; i++) drive(1'b1, 2'd0, $urandom, 4'b0000, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);
        drive(1'b0, 2'd0, '0, 4'b0000, acc);
        n_cmp++;
        if (bus.drop_count !== 8'd255 || bus.out_data_0 !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL drop_flood: got count=%0d data=%h expected 255/0badf00d", bus.drop_count, bus.out_data_0);
        end
        drive(1'b0, 2'd0, '0, 4'b1111, acc);
        reset_mid();
`endif

        // Random traffic; an unaccepted word is held stable until taken.
        acc = 1'b1;
        hv  = 1'b0;
        hs  = 2'd0;
        hd  = '0;
        for (int i = 0; i < 800; i++) begin
            if (acc || !hv) begin
                hv = ($urandom_range(0, 9) < 7);
                hs = 2'($urandom_range(0, 3));
                hd = $urandom;
            end
            drive(hv, hs, hd, 4'($urandom_range(0, 15)), acc);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, '0, 4'b1111, acc);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (exp_q[k].size() != 0) begin
                n_fail++;
                $display("FAIL drain port%0d: got %0d words left expected 0", k, exp_q[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
